// File: rtl/mux_gate_scheduler.sv
// mux_gate_scheduler: round-robin scheduler that shares a single 2:1 mux
// evaluator among N_REQ requesters to compute AND/NAND/OR/NOR/NOT.
// Every result is built from the one mux m = sel ? b : a. The mux runs in
// one pass, or in two passes for NAND/NOR, where the second pass inverts.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-requester request level            [N_REQ]
//   op         : per-requester opcode, 3 bits each      [3*N_REQ]
//   x, y       : per-requester operands                 [N_REQ]
//   gnt        : one-hot accept pulse (PASS1 cycle)     [N_REQ]
//   done       : one-hot result-valid pulse to owner    [N_REQ]
//   result     : gate result, held between operations
//   err        : illegal-opcode flag, pulses with done
//   busy       : high whenever the FSM is not IDLE
module mux_gate_scheduler #(
  parameter int unsigned N_REQ = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [3*N_REQ-1:0]   op,
  input  logic [N_REQ-1:0]     x,
  input  logic [N_REQ-1:0]     y,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  output logic                 result,
  output logic                 err,
  output logic                 busy
);

  localparam int unsigned OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PASS1 = 2'd1;
  localparam logic [1:0] S_PASS2 = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_NOT  = 3'd4;

  logic [1:0]       state, state_d;
  logic [OW-1:0]    owner, owner_d;
  logic [OW-1:0]    last_owner, last_owner_d;
  logic [2:0]       op_l, op_l_d;
  logic             x_l, x_l_d;
  logic             y_l, y_l_d;
  logic             tmp, tmp_d;
  logic [N_REQ-1:0] gnt_d, done_d;
  logic             result_d, err_d, busy_d;

  logic             sel, a, b, m;
  logic             found;
  logic [OW-1:0]    winner;
  int unsigned      idx;
  logic [2:0]       op_arr [N_REQ];

  // Split the flat opcode bus into per-requester fields
  for (genvar g = 0; g < N_REQ; g++) begin : g_op
    assign op_arr[g] = op[3*g +: 3];
  end

  // The single shared mux evaluator
  assign m = sel ? b : a;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      owner      <= '0;
      last_owner <= OW'(N_REQ - 1);
      op_l       <= '0;
      x_l        <= 1'b0;
      y_l        <= 1'b0;
      tmp        <= 1'b0;
      gnt        <= '0;
      done       <= '0;
      result     <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      last_owner <= last_owner_d;
      op_l       <= op_l_d;
      x_l        <= x_l_d;
      y_l        <= y_l_d;
      tmp        <= tmp_d;
      gnt        <= gnt_d;
      done       <= done_d;
      result     <= result_d;
      err        <= err_d;
      busy       <= busy_d;
    end
  end

  // Next-state, arbitration, mux steering and registered-output staging
  always_comb begin
    state_d      = state;
    owner_d      = owner;
    last_owner_d = last_owner;
    op_l_d       = op_l;
    x_l_d        = x_l;
    y_l_d        = y_l;
    tmp_d        = tmp;
    gnt_d        = '0;
    done_d       = '0;
    result_d     = result;
    err_d        = 1'b0;
    sel          = 1'b0;
    a            = 1'b0;
    b            = 1'b0;
    found        = 1'b0;
    winner       = '0;
    idx          = 0;

    // Round-robin search starting just after the previous owner
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = (32'(last_owner) + 32'd1 + i) % N_REQ;
      if (!found && req[OW'(idx)]) begin
        found  = 1'b1;
        winner = OW'(idx);
      end
    end

    case (state)
      S_IDLE: begin
        if (found) begin
          state_d         = S_PASS1;
          owner_d         = winner;
          last_owner_d    = winner;
          op_l_d          = op_arr[winner];
          x_l_d           = x[winner];
          y_l_d           = y[winner];
          gnt_d[winner]   = 1'b1;
        end
      end
      S_PASS1: begin
        // Illegal opcodes leave sel=a=b=0 so the mux yields 0
        case (op_l)
          OP_AND, OP_NAND: begin sel = x_l; a = 1'b0; b = y_l;  end
          OP_OR,  OP_NOR:  begin sel = x_l; a = y_l;  b = 1'b1; end
          OP_NOT:          begin sel = x_l; a = 1'b1; b = 1'b0; end
          default:         begin sel = 1'b0; a = 1'b0; b = 1'b0; end
        endcase
        tmp_d = m;
        if (op_l == OP_NAND || op_l == OP_NOR) begin
          state_d = S_PASS2;
        end else begin
          state_d       = S_DONE;
          done_d[owner] = 1'b1;
          result_d      = m;
          err_d         = (op_l > OP_NOT);
        end
      end
      S_PASS2: begin
        // Second pass inverts the first-pass value
        sel           = tmp;
        a             = 1'b1;
        b             = 1'b0;
        tmp_d         = m;
        state_d       = S_DONE;
        done_d[owner] = 1'b1;
        result_d      = m;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule
